// File: rtl/elastic_delay.sv
// Elastic valid/ready delay line of STAGES slots with bubble collapse and synchronous flush.
// Latency STAGES-1 edges from accept to data_out; stalls propagate back to in_ready combinationally,
// or through a registered skid slot when ELASTIC_DELAY_SKID_EN is defined.
module elastic_delay #(
    parameter int  WIDTH  = 32,
    parameter int  STAGES = 2,
    localparam int CNT_W  = $clog2(STAGES + 2)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] data_out,
    output logic [CNT_W-1:0] occupancy
);
    generate
        if (STAGES < 1 || STAGES > 8) begin : g_bad_stages
            $error("elastic_delay: STAGES must be in 1..8");
        end
    endgenerate

    logic [STAGES-1:0] valid_q;
    logic [WIDTH-1:0]  data_q [STAGES];
    logic [STAGES-1:0] ready;
    logic              accept;
    logic              src_vld;
    logic [WIDTH-1:0]  src_dat;

    // A slot may load when it is empty or its occupant moves on this edge.
    always_comb begin : p_ready
        logic r;
        r     = out_ready;
        ready = '0;
        for (int k = STAGES - 1; k >= 0; k--) begin
            r        = !valid_q[k] || r;
            ready[k] = r;
        end
    end

`ifdef ELASTIC_DELAY_SKID_EN
    logic             skid_valid;
    logic [WIDTH-1:0] skid_data;

    assign in_ready = !skid_valid && !flush;
    assign accept   = in_valid && in_ready;
    // A parked entry always enters slot 0 ahead of anything new.
    assign src_vld  = skid_valid || accept;
    assign src_dat  = skid_valid ? skid_data : in;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            skid_valid <= 1'b0;
            skid_data  <= '0;
        end else if (flush) begin
            skid_valid <= 1'b0;
        end else if (skid_valid) begin
            if (ready[0]) begin
                skid_valid <= 1'b0;
            end
        end else if (accept && !ready[0]) begin
            skid_valid <= 1'b1;
            skid_data  <= in;
        end
    end
`else
    assign in_ready = ready[0] && !flush;
    assign accept   = in_valid && in_ready;
    assign src_vld  = accept;
    assign src_dat  = in;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_q <= '0;
            for (int k = 0; k < STAGES; k++) begin
                data_q[k] <= '0;
            end
        end else begin
            if (ready[0]) begin
                valid_q[0] <= src_vld;
                data_q[0]  <= src_dat;
            end
            for (int k = 1; k < STAGES; k++) begin
                if (ready[k]) begin
                    valid_q[k] <= valid_q[k-1];
                    data_q[k]  <= data_q[k-1];
                end
            end
            // Data registers keep stale payload; only the valid bits are discarded.
            if (flush) begin
                valid_q <= '0;
            end
        end
    end

    always_comb begin
        occupancy = '0;
        for (int k = 0; k < STAGES; k++) begin
            occupancy = occupancy + CNT_W'(valid_q[k]);
        end
`ifdef ELASTIC_DELAY_SKID_EN
        occupancy = occupancy + CNT_W'(skid_valid);
`endif
    end

    assign out_valid = valid_q[STAGES-1];
    assign data_out  = data_q[STAGES-1];

endmodule

// File: tb/tb_elastic_delay.sv
// Randomized and directed bench for elastic_delay against a queue-of-entries reference model.
module tb_elastic_delay;
    localparam int STAGES = 2;
    localparam int CNT_W  = $clog2(STAGES + 2);
`ifdef ELASTIC_DELAY_SKID_EN
    localparam int OCC_MAX = STAGES + 1;
`else
    localparam int OCC_MAX = STAGES;
`endif

    logic             clk = 1'b0;
    logic             reset_n = 1'b1;
    logic             flush = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [31:0]      in_dat = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [31:0]      data_out;
    logic [CNT_W-1:0] occupancy;

    int vectors = 0;
    int errs = 0;

    // Reference model: FIFO of entries, each with its slot index (-1 = skid slot).
    logic [31:0] mq_dat[$];
    int          mq_pos[$];
    logic        e_ovld, e_irdy;
    logic [31:0] e_dat;
    int          e_occ;

    elastic_delay #(.WIDTH(32), .STAGES(STAGES)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in        (in_dat),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .data_out  (data_out),
        .occupancy (occupancy)
    );

    always #5 clk = ~clk;

    a_occ: assert property (@(posedge clk) disable iff (!reset_n) int'(occupancy) <= OCC_MAX)
        else $error("occupancy above limit: %0d", occupancy);
    a_hold: assert property (@(posedge clk) disable iff (!reset_n) (out_valid && !out_ready) |=> $stable(data_out))
        else $error("data_out changed while stalled");

    task automatic drive(input logic v, input logic [31:0] d, input logic o, input logic f);
        @(negedge clk);
        in_valid  = v;
        in_dat    = d;
        out_ready = o;
        flush     = f;
        #1;
        e_ovld = (mq_pos.size() > 0) && (mq_pos[0] == STAGES - 1);
        e_dat  = (mq_dat.size() > 0) ? mq_dat[0] : '0;
`ifdef ELASTIC_DELAY_SKID_EN
        e_irdy = !f && !((mq_pos.size() > 0) && (mq_pos[$] == -1));
`else
        e_irdy = !f && ((mq_pos.size() < STAGES) || o);
`endif
        e_occ  = mq_pos.size();
    endtask

    // Every entry steps one slot forward per edge unless the slot ahead stays occupied.
    task automatic commit();
        int lim;
        if (e_ovld && out_ready) begin
            void'(mq_dat.pop_front());
            void'(mq_pos.pop_front());
        end
        if (flush) begin
            mq_dat.delete();
            mq_pos.delete();
        end else begin
            lim = STAGES;
            foreach (mq_pos[i]) begin
                if (mq_pos[i] + 1 < lim) mq_pos[i] = mq_pos[i] + 1;
                lim = mq_pos[i];
            end
            if (in_valid && e_irdy) begin
                mq_dat.push_back(in_dat);
                mq_pos.push_back(lim > 0 ? 0 : -1);
            end
        end
    endtask

    task automatic drain();
        for (int c = 0; c < STAGES + 3; c++) begin
            drive(1'b0, '0, 1'b1, 1'b0);
            commit();
        end
    endtask

    task automatic test_reset();
        logic exp_v;
        #1 reset_n = 1'b0;
        mq_dat.delete();
        mq_pos.delete();
        for (int c = 0; c < 3; c++) begin
            drive(1'b1, 32'hDEADBEEF, 1'b1, 1'b0);
            vectors++; if (out_valid !== 1'b0) begin errs++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
            vectors++; if (data_out !== 32'h0) begin errs++; $display("FAIL reset_data_out got %h exp 0", data_out); end
            vectors++; if (occupancy !== '0) begin errs++; $display("FAIL reset_occupancy got %0d exp 0", occupancy); end
            vectors++; if (in_ready !== 1'b1) begin errs++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
        end
        @(negedge clk);
        in_valid = 1'b0;
        reset_n  = 1'b1;
        drive(1'b1, 32'hDEADBEEF, 1'b1, 1'b0);
        vectors++; if (in_ready !== 1'b1) begin errs++; $display("FAIL post_reset_in_ready got %b exp 1", in_ready); end
        commit();
        for (int k = 0; k <= STAGES; k++) begin
            drive(1'b0, '0, 1'b1, 1'b0);
            exp_v = (k == STAGES - 1);
            vectors++; if (out_valid !== exp_v) begin errs++; $display("FAIL reset_latency k=%0d out_valid got %b exp %b", k, out_valid, exp_v); end
            if (exp_v) begin
                vectors++; if (data_out !== 32'hDEADBEEF) begin errs++; $display("FAIL reset_latency_data got %h exp deadbeef", data_out); end
            end
            commit();
        end
    endtask

    task automatic test_stream();
        int next_exp = 1;
        drain();
        for (int i = 1; i <= 100 + STAGES; i++) begin
            drive(i <= 100, 32'(i), 1'b1, 1'b0);
            vectors++; if (in_ready !== e_irdy) begin errs++; $display("FAIL stream_in_ready i=%0d got %b exp %b", i, in_ready, e_irdy); end
            vectors++; if (out_valid !== e_ovld) begin errs++; $display("FAIL stream_out_valid i=%0d got %b exp %b", i, out_valid, e_ovld); end
            vectors++; if (int'(occupancy) != e_occ) begin errs++; $display("FAIL stream_occupancy i=%0d got %0d exp %0d", i, occupancy, e_occ); end
            if (i > STAGES && i <= 100) begin
                vectors++; if (int'(occupancy) != STAGES) begin errs++; $display("FAIL stream_steady_occ i=%0d got %0d exp %0d", i, occupancy, STAGES); end
            end
            if (e_ovld) begin
                vectors++; if (data_out !== 32'(next_exp)) begin errs++; $display("FAIL stream_order i=%0d got %0d exp %0d", i, data_out, next_exp); end
                next_exp++;
            end
            commit();
        end
        vectors++; if (next_exp != 101) begin errs++; $display("FAIL stream_count got %0d exp 101", next_exp - 1); end
    endtask

    task automatic test_stall();
        logic pending = 1'b1;
        logic exp_r;
        int   exp_o;
        drain();
        for (int i = 0; i < STAGES; i++) begin
            drive(1'b1, 32'(5 + i), 1'b0, 1'b0);
            commit();
        end
        for (int c = 0; c < 3; c++) begin
            drive(pending, 32'(5 + STAGES), 1'b0, 1'b0);
`ifdef ELASTIC_DELAY_SKID_EN
            exp_r = (c == 0);
            exp_o = (c == 0) ? STAGES : STAGES + 1;
`else
            exp_r = 1'b0;
            exp_o = STAGES;
`endif
            vectors++; if (in_ready !== exp_r) begin errs++; $display("FAIL stall_in_ready c=%0d got %b exp %b", c, in_ready, exp_r); end
            vectors++; if (int'(occupancy) != exp_o) begin errs++; $display("FAIL stall_occupancy c=%0d got %0d exp %0d", c, occupancy, exp_o); end
            if (pending && e_irdy) pending = 1'b0;
            commit();
        end
        for (int c = 0; c <= STAGES; c++) begin
            drive(pending, 32'(5 + STAGES), 1'b1, 1'b0);
            if (c == 0) begin
`ifdef ELASTIC_DELAY_SKID_EN
                vectors++; if (in_ready !== 1'b0) begin errs++; $display("FAIL release_in_ready got %b exp 0", in_ready); end
`else
                vectors++; if (in_ready !== 1'b1) begin errs++; $display("FAIL release_in_ready got %b exp 1", in_ready); end
`endif
            end
            vectors++; if (out_valid !== 1'b1) begin errs++; $display("FAIL drain_out_valid c=%0d got %b exp 1", c, out_valid); end
            vectors++; if (data_out !== 32'(5 + c)) begin errs++; $display("FAIL drain_data c=%0d got %0d exp %0d", c, data_out, 5 + c); end
            if (pending && e_irdy) pending = 1'b0;
            commit();
        end
    endtask

    task automatic test_bubble();
        logic exp_v;
        drain();
        drive(1'b1, 32'hA, 1'b0, 1'b0);
        vectors++; if (in_ready !== 1'b1) begin errs++; $display("FAIL bubble_accept got %b exp 1", in_ready); end
        commit();
        for (int k = 0; k <= STAGES; k++) begin
            drive(1'b0, '0, 1'b0, 1'b0);
            exp_v = (k >= STAGES - 1);
            vectors++; if (in_ready !== 1'b1) begin errs++; $display("FAIL bubble_in_ready k=%0d got %b exp 1", k, in_ready); end
            vectors++; if (int'(occupancy) != 1) begin errs++; $display("FAIL bubble_occupancy k=%0d got %0d exp 1", k, occupancy); end
            vectors++; if (out_valid !== exp_v) begin errs++; $display("FAIL bubble_out_valid k=%0d got %b exp %b", k, out_valid, exp_v); end
            if (exp_v) begin
                vectors++; if (data_out !== 32'hA) begin errs++; $display("FAIL bubble_data got %h exp a", data_out); end
            end
            commit();
        end
    endtask

    task automatic test_flush();
        drain();
        drive(1'b1, 32'h11, 1'b0, 1'b0); commit();
        drive(1'b1, 32'h22, 1'b0, 1'b0); commit();
        drive(1'b1, 32'h33, 1'b0, 1'b1);
        vectors++; if (in_ready !== 1'b0) begin errs++; $display("FAIL flush_in_ready got %b exp 0", in_ready); end
        commit();
        for (int c = 0; c < STAGES + 2; c++) begin
            drive(1'b0, '0, 1'b1, 1'b0);
            vectors++; if (out_valid !== 1'b0) begin errs++; $display("FAIL flush_out_valid c=%0d got %b exp 0", c, out_valid); end
            vectors++; if (occupancy !== '0) begin errs++; $display("FAIL flush_occupancy c=%0d got %0d exp 0", c, occupancy); end
            commit();
        end
        drive(1'b1, 32'h55, 1'b1, 1'b0); commit();
        drive(1'b1, 32'h66, 1'b1, 1'b0); commit();
        drive(1'b0, '0, 1'b1, 1'b1);
        vectors++; if (out_valid !== e_ovld) begin errs++; $display("FAIL flush_xfer_valid got %b exp %b", out_valid, e_ovld); end
        if (e_ovld) begin
            vectors++; if (data_out !== e_dat) begin errs++; $display("FAIL flush_xfer_data got %h exp %h", data_out, e_dat); end
        end
        commit();
        drive(1'b0, '0, 1'b1, 1'b0);
        vectors++; if (out_valid !== 1'b0) begin errs++; $display("FAIL flush2_out_valid got %b exp 0", out_valid); end
        vectors++; if (occupancy !== '0) begin errs++; $display("FAIL flush2_occupancy got %0d exp 0", occupancy); end
        commit();
    endtask

`ifdef ELASTIC_DELAY_SKID_EN
    task automatic test_skid();
        logic [31:0] exp_q[$];
        drain();
        for (int i = 0; i < STAGES; i++) begin
            drive(1'b1, 32'(17 * (i + 1)), 1'b0, 1'b0);
            exp_q.push_back(32'(17 * (i + 1)));
            commit();
        end
        drive(1'b1, 32'h44, 1'b0, 1'b0);
        exp_q.push_back(32'h44);
        vectors++; if (in_ready !== 1'b1) begin errs++; $display("FAIL skid_accept got %b exp 1", in_ready); end
        commit();
        drive(1'b0, '0, 1'b0, 1'b0);
        vectors++; if (in_ready !== 1'b0) begin errs++; $display("FAIL skid_in_ready got %b exp 0", in_ready); end
        vectors++; if (int'(occupancy) != STAGES + 1) begin errs++; $display("FAIL skid_occupancy got %0d exp %0d", occupancy, STAGES + 1); end
        commit();
        for (int c = 0; c <= STAGES; c++) begin
            drive(1'b0, '0, 1'b1, 1'b0);
            vectors++; if (out_valid !== 1'b1) begin errs++; $display("FAIL skid_drain_valid c=%0d got %b exp 1", c, out_valid); end
            vectors++; if (data_out !== exp_q[c]) begin errs++; $display("FAIL skid_drain_data c=%0d got %h exp %h", c, data_out, exp_q[c]); end
            commit();
        end
    endtask
`endif

    task automatic test_midreset();
        drain();
        for (int i = 0; i < STAGES; i++) begin
            drive(1'b1, 32'(192 + i), 1'b0, 1'b0);
            commit();
        end
        drive(1'b1, 32'hCC, 1'b0, 1'b0);
        #1 reset_n = 1'b0;
        #1;
        vectors++; if (out_valid !== 1'b0) begin errs++; $display("FAIL midreset_out_valid got %b exp 0", out_valid); end
        vectors++; if (data_out !== 32'h0) begin errs++; $display("FAIL midreset_data got %h exp 0", data_out); end
        vectors++; if (occupancy !== '0) begin errs++; $display("FAIL midreset_occupancy got %0d exp 0", occupancy); end
        vectors++; if (in_ready !== 1'b1) begin errs++; $display("FAIL midreset_in_ready got %b exp 1", in_ready); end
        mq_dat.delete();
        mq_pos.delete();
        @(negedge clk);
        in_valid = 1'b0;
        reset_n  = 1'b1;
        drive(1'b0, '0, 1'b1, 1'b0);
        vectors++; if (out_valid !== 1'b0) begin errs++; $display("FAIL midreset_after_valid got %b exp 0", out_valid); end
        commit();
    endtask

    task automatic test_random();
        logic        hold = 1'b0;
        logic        v = 1'b0;
        logic        o;
        logic        f;
        logic [31:0] d = '0;
        int          pv, po;
        drain();
        for (int n = 0; n < 3000; n++) begin
            pv = ((n / 400) % 2 == 1) ? 90 : 60;
            po = ((n / 500) % 2 == 1) ? 25 : 80;
            if (!hold) begin
                v = ($urandom_range(0, 99) < pv);
                d = $urandom;
            end
            o = ($urandom_range(0, 99) < po);
            f = ($urandom_range(0, 49) == 0);
            drive(v, d, o, f);
            vectors++; if (in_ready !== e_irdy) begin errs++; $display("FAIL rand_in_ready n=%0d got %b exp %b", n, in_ready, e_irdy); end
            vectors++; if (out_valid !== e_ovld) begin errs++; $display("FAIL rand_out_valid n=%0d got %b exp %b", n, out_valid, e_ovld); end
            vectors++; if (int'(occupancy) != e_occ) begin errs++; $display("FAIL rand_occupancy n=%0d got %0d exp %0d", n, occupancy, e_occ); end
            if (e_ovld) begin
                vectors++; if (data_out !== e_dat) begin errs++; $display("FAIL rand_data n=%0d got %h exp %h", n, data_out, e_dat); end
            end
            hold = v && !e_irdy;
            commit();
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_bubble();
        test_flush();
`ifdef ELASTIC_DELAY_SKID_EN
        test_skid();
`endif
        test_midreset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule
